// File: rtl/a2d_sched_pkg.sv
// Shared types for the A2D round scheduler: FSM states, channel slots and
// the ADC128S command-word builder.
package a2d_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        WAIT_SEL,
        GAP,
        RD,
        WAIT_RD,
        STORE
    } state_t;

    // Slot order in a round; the value doubles as the vld bit position.
    typedef enum logic [1:0] {
        LFT  = 2'd0,
        RGHT = 2'd1,
        BATT = 2'd2
    } chan_t;

    function automatic logic [15:0] build_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_scheduler.sv
// Runs one left/right/battery conversion round through the A2D SPI master on
// every sample tick and holds the latest 12-bit results for the consumers.
module a2d_scheduler
    import a2d_sched_pkg::*;
#(
    parameter int          PERIOD_CYC  = 2**16,
    parameter int          GAP_CYC     = 8,
    parameter int          TIMEOUT_CYC = 4096,
    parameter logic [2:0]  CH_LFT      = 3'd0,
    parameter logic [2:0]  CH_RGHT     = 3'd4,
    parameter logic [2:0]  CH_BATT     = 3'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic [2:0]  vld,
    output logic        rnd_done,
    output logic        overrun,
    output logic        tmo_err
);

    localparam int PW = $clog2(PERIOD_CYC);
    localparam int CW = $clog2((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC) + 1;

    state_t         state_q, state_d;
    chan_t          idx_q, idx_d;
    logic [PW-1:0]  per_q, per_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           pend_q, pend_d;
    logic           wrt_q, wrt_d;
    logic [15:0]    cmd_q, cmd_d;
    logic [11:0]    lft_q, lft_d;
    logic [11:0]    rght_q, rght_d;
    logic [11:0]    batt_q, batt_d;
    logic [2:0]     vld_q, vld_d;
    logic           rnd_q, rnd_d;
    logic           ovr_q, ovr_d;
    logic           tmo_q, tmo_d;

    logic           tick;
    logic           consume;
    logic           cnt_tmo;
    logic [2:0]     cur_ch;
    logic           unused_rd_hi;

    // The upper read-data nibble carries no conversion bits.
    assign unused_rd_hi = ^rd_data[15:12];

    assign tick    = (per_q == PW'(PERIOD_CYC - 1));
    assign cnt_tmo = (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        cur_ch = CH_BATT;
        case (idx_q)
            LFT:     cur_ch = CH_LFT;
            RGHT:    cur_ch = CH_RGHT;
            default: cur_ch = CH_BATT;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        lft_d   = lft_q;
        rght_d  = rght_q;
        batt_d  = batt_q;
        vld_d   = vld_q;
        tmo_d   = tmo_q;
        wrt_d   = 1'b0;
        rnd_d   = 1'b0;
        consume = 1'b0;
        per_d   = tick ? '0 : per_q + PW'(1);

        case (state_q)
            IDLE: begin
                if (pend_q && en) begin
                    consume = 1'b1;
                    idx_d   = LFT;
                    state_d = SEL;
                end
            end
            SEL: begin
                wrt_d   = 1'b1;
                cmd_d   = build_cmd(cur_ch);
                cnt_d   = '0;
                state_d = WAIT_SEL;
            end
            // Data returned here belongs to the previously selected channel.
            WAIT_SEL: begin
                if (done) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (cnt_tmo) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    state_d = RD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RD: begin
                wrt_d   = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_RD;
            end
            WAIT_RD: begin
                if (done) begin
                    case (idx_q)
                        LFT:     lft_d  = rd_data[11:0];
                        RGHT:    rght_d = rd_data[11:0];
                        default: batt_d = rd_data[11:0];
                    endcase
                    vld_d[idx_q] = 1'b1;
                    state_d      = STORE;
                end else if (cnt_tmo) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STORE: begin
                case (idx_q)
                    LFT: begin
                        idx_d   = RGHT;
                        state_d = SEL;
                    end
                    RGHT: begin
                        idx_d   = BATT;
                        state_d = SEL;
                    end
                    default: begin
                        rnd_d   = 1'b1;
                        state_d = IDLE;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase

        // A tick landing on the consume cycle re-arms pending without overrun.
        pend_d = tick | (pend_q & ~consume);
        ovr_d  = ovr_q | (tick & pend_q & ~consume);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= LFT;
            per_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            wrt_q   <= 1'b0;
            cmd_q   <= 16'h0000;
            lft_q   <= 12'h000;
            rght_q  <= 12'h000;
            batt_q  <= 12'h000;
            vld_q   <= 3'b000;
            rnd_q   <= 1'b0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            per_q   <= per_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            wrt_q   <= wrt_d;
            cmd_q   <= cmd_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
            batt_q  <= batt_d;
            vld_q   <= vld_d;
            rnd_q   <= rnd_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign wrt      = wrt_q;
    assign cmd      = cmd_q;
    assign lft_ld   = lft_q;
    assign rght_ld  = rght_q;
    assign batt     = batt_q;
    assign vld      = vld_q;
    assign rnd_done = rnd_q;
    assign overrun  = ovr_q;
    assign tmo_err  = tmo_q;

endmodule

// File: tb/tb_a2d_scheduler.sv
// Bench for a2d_scheduler: an SPI master + ADC128S model answers each
// transaction with the conversion of the previously selected channel.
module tb_a2d_scheduler;

    localparam int PER = 1024;
    localparam int GAP = 8;
    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst, en, done;
    logic [15:0] rd_data;
    logic        wrt, rnd_done, overrun, tmo_err;
    logic [15:0] cmd;
    logic [11:0] lft_ld, rght_ld, batt;
    logic [2:0]  vld;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rnd_cnt = 0;

    logic [11:0] adc [8];
    logic [15:0] cmd_log [$];
    int          wrt_cyc [$];
    int          done_cyc [$];
    int          wrt_seen = 0;
    int          suppress_idx = -1;
    int          inject_req = 0;

    a2d_scheduler #(
        .PERIOD_CYC (PER),
        .GAP_CYC    (GAP),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .wrt     (wrt),
        .cmd     (cmd),
        .done    (done),
        .rd_data (rd_data),
        .lft_ld  (lft_ld),
        .rght_ld (rght_ld),
        .batt    (batt),
        .vld     (vld),
        .rnd_done(rnd_done),
        .overrun (overrun),
        .tmo_err (tmo_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rnd_done === 1'b1) rnd_cnt <= rnd_cnt + 1;

    // SPI master + ADC: each reply carries the channel chosen by the prior command.
    initial begin : spi_model
        int lat;
        int ack;
        logic [2:0] prev, ch;
        ack = 0;
        prev = 3'd0;
        done = 1'b0;
        rd_data = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            done = 1'b0;
            if (wrt === 1'b1) begin
                ch = cmd[13:11];
                wrt_seen++;
                cmd_log.push_back(cmd);
                wrt_cyc.push_back(cyc);
                lat = $urandom_range(2, 10);
                repeat (lat) @(posedge clk);
                #1;
                if (wrt_seen != suppress_idx) begin
                    rd_data = {4'($urandom), adc[prev]};
                    done = 1'b1;
                    done_cyc.push_back(cyc);
                end
                prev = ch;
            end else if (inject_req != ack) begin
                ack = inject_req;
                rd_data = 16'h0ABC;
                done = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_round(input int budget, input string tag);
        int r0;
        int n;
        r0 = rnd_cnt;
        n = 0;
        while (rnd_cnt == r0 && n < budget) begin
            cycles(1);
            n++;
        end
        chk(tag, 32'(rnd_cnt != r0), 32'd1);
    endtask

    task automatic wait_wrts(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (wrt_seen < target && n < budget) begin
            cycles(1);
            n++;
        end
        chk(tag, 32'(wrt_seen >= target), 32'd1);
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_lft"},  32'(lft_ld),  32'(adc[0]));
        chk({tag, "_rght"}, 32'(rght_ld), 32'(adc[4]));
        chk({tag, "_batt"}, 32'(batt),    32'(adc[5]));
        chk({tag, "_vld"},  32'(vld),     32'h7);
    endtask

    task automatic new_samples();
        adc[0] = 12'($urandom);
        adc[4] = 12'($urandom);
        adc[5] = 12'($urandom);
    endtask

    initial begin : main
        int w0, r0, n, d0;
        logic [15:0] exp_cmd [6];
        exp_cmd[0] = 16'h0000; exp_cmd[1] = 16'h0000;
        exp_cmd[2] = 16'h2000; exp_cmd[3] = 16'h2000;
        exp_cmd[4] = 16'h2800; exp_cmd[5] = 16'h2800;
        for (int i = 0; i < 8; i++) adc[i] = 12'($urandom);
        adc[0] = 12'h300;
        adc[4] = 12'h2A0;
        adc[5] = 12'hC00;

        rst = 1'b1;
        en  = 1'b0;
        cycles(3);
        chk("rst_wrt",      32'(wrt),      32'd0);
        chk("rst_cmd",      32'(cmd),      32'h0);
        chk("rst_lft",      32'(lft_ld),   32'h0);
        chk("rst_rght",     32'(rght_ld),  32'h0);
        chk("rst_batt",     32'(batt),     32'h0);
        chk("rst_vld",      32'(vld),      32'h0);
        chk("rst_rnd_done", 32'(rnd_done), 32'd0);
        chk("rst_overrun",  32'(overrun),  32'd0);
        chk("rst_tmo_err",  32'(tmo_err),  32'd0);
        rst = 1'b0;

        // Disabled: ticks accumulate into pending/overrun but nothing launches.
        w0 = wrt_seen;
        cycles(3 * PER);
        chk("en0_no_wrt", 32'(wrt_seen), 32'(w0));
        chk("en0_overrun", 32'(overrun), 32'd1);

        r0 = rnd_cnt;
        en = 1'b1;
        n = 0;
        while (wrt !== 1'b1 && n < 2) begin
            cycles(1);
            n++;
        end
        chk("pending_start", 32'(wrt), 32'd1);
        wait_round(400, "round1_done");
        chk_regs("round1");
        cycles(20);
        chk("round1_one_pulse", 32'(rnd_cnt - r0), 32'd1);
        chk("round1_wrts", 32'(cmd_log.size()), 32'd6);
        if (cmd_log.size() >= 6 && done_cyc.size() >= 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("cmd_seq%0d", i), 32'(cmd_log[i]), 32'(exp_cmd[i]));
            for (int j = 0; j < 3; j++)
                chk($sformatf("gap%0d", j), 32'((wrt_cyc[2*j+1] - done_cyc[2*j]) > GAP), 32'd1);
        end

        // Randomized rounds against the ADC model.
        for (int r = 0; r < 3; r++) begin
            new_samples();
            wait_round(PER + 400, $sformatf("rand%0d_done", r));
            chk_regs($sformatf("rand%0d", r));
        end

        // en dropped during the right-cell select: round still finishes.
        new_samples();
        wait_wrts(wrt_seen + 3, PER + 400, "endrop_reach_rght");
        en = 1'b0;
        wait_round(400, "endrop_round_done");
        chk_regs("endrop");
        w0 = wrt_seen;
        cycles(PER + 200);
        chk("endrop_idle", 32'(wrt_seen), 32'(w0));
        new_samples();
        en = 1'b1;
        wait_round(400, "reen_round_done");
        chk_regs("reen");

        // Reset in GAP, then a stray done.
        d0 = done_cyc.size();
        n = 0;
        while (done_cyc.size() == d0 && n < PER + 400) begin
            cycles(1);
            n++;
        end
        chk("gap_reach", 32'(done_cyc.size() > d0), 32'd1);
        cycles(3);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        chk("gaprst_wrt",     32'(wrt),     32'd0);
        chk("gaprst_cmd",     32'(cmd),     32'h0);
        chk("gaprst_vld",     32'(vld),     32'h0);
        chk("gaprst_lft",     32'(lft_ld),  32'h0);
        chk("gaprst_rght",    32'(rght_ld), 32'h0);
        chk("gaprst_batt",    32'(batt),    32'h0);
        chk("gaprst_overrun", 32'(overrun), 32'd0);
        w0 = wrt_seen;
        inject_req++;
        cycles(6);
        chk("stray_vld", 32'(vld),      32'h0);
        chk("stray_lft", 32'(lft_ld),   32'h0);
        chk("stray_wrt", 32'(wrt_seen), 32'(w0));

        // Timeout on the left-cell read transaction.
        new_samples();
        suppress_idx = wrt_seen + 2;
        wait_wrts(suppress_idx, PER + 400, "tmo_reach_rd");
        cycles(TMO - 10);
        chk("tmo_not_early", 32'(tmo_err), 32'd0);
        n = 0;
        while (tmo_err !== 1'b1 && n < 30) begin
            cycles(1);
            n++;
        end
        chk("tmo_set", 32'(tmo_err), 32'd1);
        chk("tmo_vld", 32'(vld),     32'h0);
        chk("tmo_lft", 32'(lft_ld),  32'h0);
        w0 = wrt_seen;
        cycles(50);
        chk("tmo_idle", 32'(wrt_seen), 32'(w0));
        wait_round(PER + 400, "post_tmo_done");
        chk_regs("post_tmo");
        chk("tmo_sticky", 32'(tmo_err), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/a2d_scheduler.md
Name: a2d_scheduler

Overview:
- Sequences the shared ADC128S A2D through the existing SPI master (16-bit transactions, wrt/done handshake).
- On each sample tick it runs one round: left load cell, then right load cell, then battery.
- Each channel takes two SPI transactions: the first selects the channel, the second returns its 12-bit result.
- Results are held in registers for the balance, rider-detect and battery-monitor logic. The Segway top level instantiates it between the sensor consumers and the A2D SPI master.

Parameters:
- PERIOD_CYC, 2**16, clk cycles between sample ticks (minimum 256).
- GAP_CYC, 8, idle clk cycles between the two SPI transactions of one channel (SS_n high time).
- TIMEOUT_CYC, 4096, max clk cycles waiting for done before the transaction is abandoned.
- CH_LFT, 3'd0, ADC channel of the left load cell.
- CH_RGHT, 3'd4, ADC channel of the right load cell.
- CH_BATT, 3'd5, ADC channel of the battery.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  scheduler enable; when low, no new round starts.
- wrt  out  1  one-cycle strobe to the SPI master to start a transaction.
- cmd  out  16  SPI command word {2'b00, ch[2:0], 11'h000}.
- done  in  1  SPI master transaction-complete pulse.
- rd_data  in  16  SPI master read data; bits [11:0] hold the result.
- lft_ld  out  12  latest left load-cell sample.
- rght_ld  out  12  latest right load-cell sample.
- batt  out  12  latest battery sample.
- vld  out  3  per-channel sample-valid flags {batt, rght, lft}; sticky.
- rnd_done  out  1  one-cycle pulse when a round stores its battery result.
- overrun  out  1  sticky flag: a tick arrived while a tick was already pending.
- tmo_err  out  1  sticky flag: an SPI transaction timed out.

Behaviour:
- Reset values: wrt, rnd_done, overrun, tmo_err = 0; cmd = 16'h0000; all sample registers = 12'h000; vld = 3'b000. Period counter = 0, pending = 0, FSM in IDLE, channel index = LFT.
- Period counter: free-running; wraps at PERIOD_CYC-1 and raises tick for one cycle. It runs regardless of en.
- pending flag: set on tick, cleared when IDLE launches a round. If tick arrives while pending=1 and not cleared that same cycle, set overrun. Excess ticks are dropped, never queued.
- FSM states: IDLE, SEL, WAIT_SEL, GAP, RD, WAIT_RD, STORE.
- IDLE: if pending && en, clear pending, set index = LFT, go to SEL.
- SEL: assert wrt for one cycle with cmd for the current channel; go to WAIT_SEL.
- WAIT_SEL: on done, go to GAP. rd_data is ignored here (it is the previous conversion).
- GAP: count GAP_CYC cycles, then go to RD.
- RD: assert wrt for one cycle with the same cmd; go to WAIT_RD.
- WAIT_RD: on done, capture rd_data[11:0] into the indexed register and set its vld bit in the same edge; go to STORE.
- STORE: advance index LFT -> RGHT -> BATT. After BATT, pulse rnd_done and go to IDLE; otherwise go to SEL.
- Latency: sample registers update on the clock edge after done is seen in WAIT_RD.
- cmd holds its value between transactions; it changes only in SEL.
- Timeout: in WAIT_SEL or WAIT_RD, a cycle counter reset on wrt counts up. Reaching TIMEOUT_CYC without done sets tmo_err and returns to IDLE. Registers already stored in that round are kept; the others keep their old value and vld.
- done outside WAIT_SEL/WAIT_RD is ignored.
- en dropping mid-round: the round completes; en only gates round start.
- tick in the same cycle IDLE consumes pending: pending stays set, overrun is not set.
- rst mid-transaction: FSM returns to IDLE next edge, wrt low, all outputs to reset values. An in-flight SPI transaction is abandoned, and a later done is ignored.
- Sticky flags clear only on rst.

Decomposition:
- Package a2d_sched_pkg holds:
  - the state enum (state_t);
  - the channel-index enum (LFT, RGHT, BATT);
  - a function building cmd from a 3-bit channel.
- No sub-module; the period counter, gap/timeout counter and FSM sit in one module. The gap and timeout counts share one counter, since their states are disjoint.

Test Plan:
- Reset, then en=1 with an SPI master plus ADC model (lft_cell_set=12'h300, rght_cell_set=12'h2A0, batt_set=12'hC00). After the first round: lft_ld=12'h300, rght_ld=12'h2A0, batt=12'hC00, vld=3'b111, exactly one rnd_done pulse.
- Command sequence check: first six wrt strobes carry cmd = 16'h0000, 16'h0000, 16'h2000, 16'h2000, 16'h2800, 16'h2800. Gap between each WAIT_SEL done and the following wrt is >= GAP_CYC cycles.
- en=0 from reset: no wrt for 3*PERIOD_CYC cycles. Set en=1: a round starts within 2 cycles because pending is already set, and overrun=1 from the extra ticks.
- Drop en during the rght_ld transaction: the round completes, batt is updated and rnd_done pulses; no further wrt until en=1 and the next tick.
- Suppress done after the second wrt (left-cell read transaction) in round 1: after TIMEOUT_CYC cycles tmo_err=1, FSM is in IDLE and vld=3'b000. The next tick with done restored completes a normal round, and tmo_err stays 1.
- Assert rst for one cycle in the GAP state: next cycle wrt=0, vld=0, sample registers = 0. A stray done afterwards causes no update.
